// File: rtl/lc4_div_pkg.sv
// Shared definitions for the iterative LC4 divider: FSM encoding and widths.
package lc4_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_W = 16;
    localparam int CNT_W = $clog2(16) + 1;

endpackage

// File: rtl/cla16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a lookahead carry
// unit across the groups.
module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    assign g = a & b;
    assign p = a ^ b;

    // Group generate/propagate for each nibble.
    always_comb begin
        gg = '0;
        gp = '0;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
    end

    assign gc[0] = cin;
    assign gc[1] = gg[0] | (gp[0] & cin);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    assign cout  = gc[4];

    // Sum bits: carries ripple only inside a nibble, seeded by the group carry.
    always_comb begin
        logic carry;
        sum   = '0;
        carry = 1'b0;
        for (int j = 0; j < 4; j++) begin
            carry = gc[j];
            for (int k = 0; k < 4; k++) begin
                sum[4*j+k] = p[4*j+k] ^ carry;
                carry      = g[4*j+k] | (p[4*j+k] & carry);
            end
        end
    end

endmodule

// File: rtl/lc4_div_step.sv
// One combinational restoring-division step. The adder carry-out of
// sh + ~divisor + 1 is the "no borrow" flag, i.e. sh >= divisor; the bit
// shifted out of rem extends that to a 17-bit comparison.
module lc4_div_step
    import lc4_div_pkg::*;
(
    input  logic [DIV_W-1:0] rem,
    input  logic [DIV_W-1:0] quot,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] rem_nx,
    output logic [DIV_W-1:0] quot_nx
);

    logic [DIV_W-1:0] sh;
    logic [DIV_W-1:0] diff;
    logic             carry;
    logic             no_borrow;
    logic             ok;

    assign sh    = {rem[DIV_W-2:0], quot[DIV_W-1]};
    assign carry = rem[DIV_W-1];

    cla16 u_cla (
        .a    (sh),
        .b    (~divisor),
        .cin  (1'b1),
        .sum  (diff),
        .cout (no_borrow)
    );

    assign ok      = carry | no_borrow;
    assign rem_nx  = ok ? diff : sh;
    assign quot_nx = {quot[DIV_W-2:0], ok};

endmodule

// File: rtl/lc4_divider_iter.sv
// Iterative 16-bit unsigned divider behind a valid/ready handshake.
// STEPS_PER_CYCLE restoring steps are chained per clock (1, 2 or 4).
module lc4_divider_iter
    import lc4_div_pkg::*;
#(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [DIV_W-1:0] i_dividend,
    input  logic [DIV_W-1:0] i_divisor,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [DIV_W-1:0] o_quotient,
    output logic [DIV_W-1:0] o_remainder
);

    localparam int N = DIV_W / STEPS_PER_CYCLE;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] count;
    logic [DIV_W-1:0] quot;
    logic [DIV_W-1:0] rem;
    logic [DIV_W-1:0] divisor;
    logic             accept;

    logic [DIV_W-1:0] rem_c  [STEPS_PER_CYCLE+1];
    logic [DIV_W-1:0] quot_c [STEPS_PER_CYCLE+1];

    assign rem_c[0]  = rem;
    assign quot_c[0] = quot;

    for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
        lc4_div_step u_step (
            .rem     (rem_c[i]),
            .quot    (quot_c[i]),
            .divisor (divisor),
            .rem_nx  (rem_c[i+1]),
            .quot_nx (quot_c[i+1])
        );
    end

    assign i_ready     = (state == IDLE);
    assign o_valid     = (state == DONE);
    assign o_quotient  = quot;
    assign o_remainder = rem;
    assign accept      = i_valid & i_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; a zero divisor skips straight to DONE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (i_divisor == '0) ? DONE : RUN;
            RUN:  if (count == CNT_W'(1)) state_nx = DONE;
            DONE: if (o_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Divisor latch; only meaningful while RUN, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) divisor <= i_divisor;
    end

    // Counter and quotient/remainder registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            quot  <= '0;
            rem   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem <= '0;
                        if (i_divisor != '0) begin
                            quot  <= i_dividend;
                            count <= CNT_W'(N);
                        end else begin
                            quot  <= '0;
                        end
                    end
                end
                RUN: begin
                    quot  <= quot_c[STEPS_PER_CYCLE];
                    rem   <= rem_c[STEPS_PER_CYCLE];
                    count <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lc4_divider_iter.sv
// Self-checking bench: three divider instances (1, 2 and 4 steps per cycle)
// share stimulus; results, latency and handshake behaviour are compared.
module tb_lc4_divider_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_dividend;
    logic [15:0] i_divisor;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [15:0] q [3];
    logic [15:0] r [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lc4_divider_iter #(.STEPS_PER_CYCLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(ir[0]),
        .i_dividend(i_dividend), .i_divisor(i_divisor), .o_valid(ov[0]),
        .o_ready(o_ready), .o_quotient(q[0]), .o_remainder(r[0]));

    lc4_divider_iter #(.STEPS_PER_CYCLE(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(ir[1]),
        .i_dividend(i_dividend), .i_divisor(i_divisor), .o_valid(ov[1]),
        .o_ready(o_ready), .o_quotient(q[1]), .o_remainder(r[1]));

    lc4_divider_iter #(.STEPS_PER_CYCLE(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(ir[2]),
        .i_dividend(i_dividend), .i_divisor(i_divisor), .o_valid(ov[2]),
        .o_ready(o_ready), .o_quotient(q[2]), .o_remainder(r[2]));

    typedef struct {
        logic [15:0] dd;
        logic [15:0] dv;
        logic [15:0] eq;
        logic [15:0] er;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input int d, input logic [15:0] dv);
        return (dv == 16'd0) ? 1 : (16 / (1 << d)) + 1;
    endfunction

    // One transaction with o_ready high; checks latency, result and return to idle.
    task automatic do_op(input logic [15:0] dd, input logic [15:0] dv,
                         input logic use_exp, input logic [15:0] eq,
                         input logic [15:0] er, input string tag);
        int          lat  [3];
        logic [15:0] gq   [3];
        logic [15:0] gr   [3];
        bit          seen [3];
        bit          done [3];
        for (int d = 0; d < 3; d++) begin
            lat[d] = 0; gq[d] = '0; gr[d] = '0; seen[d] = 0; done[d] = 0;
        end
        @(negedge clk);
        check($sformatf("%s idle before", tag), {29'd0, ir}, 32'h7);
        i_dividend = dd;
        i_divisor  = dv;
        i_valid    = 1'b1;
        o_ready    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            for (int d = 0; d < 3; d++) begin
                if (!seen[d] && ov[d]) begin
                    seen[d] = 1; lat[d] = k; gq[d] = q[d]; gr[d] = r[d];
                end else if (seen[d] && !done[d] && k == lat[d] + 1) begin
                    check($sformatf("%s s%0d i_ready after", tag, 1 << d), {31'd0, ir[d]}, 32'd1);
                    check($sformatf("%s s%0d o_valid after", tag, 1 << d), {31'd0, ov[d]}, 32'd0);
                    done[d] = 1;
                end
            end
            if (done[0] && done[1] && done[2]) break;
            @(negedge clk);
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s s%0d completed", tag, 1 << d), {31'd0, done[d]}, 32'd1);
            if (done[d]) begin
                check($sformatf("%s s%0d latency", tag, 1 << d), lat[d], lat_of(d, dv));
                if (use_exp) begin
                    check($sformatf("%s s%0d quotient", tag, 1 << d), {16'd0, gq[d]}, {16'd0, eq});
                    check($sformatf("%s s%0d remainder", tag, 1 << d), {16'd0, gr[d]}, {16'd0, er});
                end else if (dv == 16'd0) begin
                    check($sformatf("%s s%0d q div0", tag, 1 << d), {16'd0, gq[d]}, 32'd0);
                    check($sformatf("%s s%0d r div0", tag, 1 << d), {16'd0, gr[d]}, 32'd0);
                end else begin
                    check($sformatf("%s s%0d q*d+r", tag, 1 << d),
                          32'(gq[d]) * 32'(dv) + 32'(gr[d]), 32'(dd));
                    check($sformatf("%s s%0d r<d", tag, 1 << d), {31'd0, gr[d] < dv}, 32'd1);
                end
            end
        end
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{16'd100,  16'd7,      16'd14,     16'd2};
        vecs[1] = '{16'hFFFF, 16'h0001,   16'hFFFF,   16'h0000};
        vecs[2] = '{16'hFFFE, 16'h8001,   16'h0001,   16'h7FFD};
        vecs[3] = '{16'd5,    16'd0,      16'd0,      16'd0};
        vecs[4] = '{16'd1000, 16'd3,      16'd333,    16'd1};
        vecs[5] = '{16'h1234, 16'h0011,   16'h0112,   16'h0002};
        vecs[6] = '{16'd0,    16'd5,      16'd0,      16'd0};
        vecs[7] = '{16'd7,    16'd100,    16'd0,      16'd7};
        vecs[8] = '{16'hFFFF, 16'hFFFF,   16'h0001,   16'h0000};
        vecs[9] = '{16'hFFFF, 16'h00FF,   16'h0101,   16'h0000};

        rst_n = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
        i_dividend = '0; i_divisor = '0;
        repeat (3) @(negedge clk);
        check("reset i_ready", {29'd0, ir}, 32'h7);
        check("reset o_valid", {29'd0, ov}, 32'h0);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset s%0d q", 1 << d), {16'd0, q[d]}, 32'd0);
            check($sformatf("reset s%0d r", 1 << d), {16'd0, r[d]}, 32'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            do_op(vecs[i].dd, vecs[i].dv, 1'b1, vecs[i].eq, vecs[i].er, $sformatf("vec%0d", i));

        // Back-pressure with i_valid noise while busy.
        begin
            int k17;
            k17 = 0;
            @(negedge clk);
            i_dividend = 16'd1000; i_divisor = 16'd3; i_valid = 1'b1; o_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            i_dividend = 16'd7; i_divisor = 16'd1;
            for (int k = 1; k <= 40; k++) begin
                if (ov[0]) begin k17 = k; break; end
                check($sformatf("bp busy i_ready c%0d", k), {29'd0, ir}, 32'h0);
                @(negedge clk);
            end
            check("bp latency", k17, 17);
            for (int h = 0; h < 6; h++) begin
                check($sformatf("bp hold o_valid %0d", h), {29'd0, ov}, 32'h7);
                for (int d = 0; d < 3; d++) begin
                    check($sformatf("bp hold s%0d q %0d", 1 << d, h), {16'd0, q[d]}, 32'd333);
                    check($sformatf("bp hold s%0d r %0d", 1 << d, h), {16'd0, r[d]}, 32'd1);
                end
                if (h < 5) @(negedge clk);
            end
            o_ready = 1'b1;
            @(negedge clk);
            check("bp release i_ready", {29'd0, ir}, 32'h7);
            check("bp release o_valid", {29'd0, ov}, 32'h0);
            i_valid = 1'b0;
            @(negedge clk);
            check("bp no accept on release", {29'd0, ir}, 32'h7);
        end

        // Reset in the middle of a divide.
        @(negedge clk);
        i_dividend = 16'h1234; i_divisor = 16'h0011; i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst i_ready", {29'd0, ir}, 32'h7);
        check("midrst o_valid", {29'd0, ov}, 32'h0);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("midrst s%0d q", 1 << d), {16'd0, q[d]}, 32'd0);
            check($sformatf("midrst s%0d r", 1 << d), {16'd0, r[d]}, 32'd0);
        end
        rst_n = 1'b1;
        do_op(16'd9, 16'd4, 1'b1, 16'd2, 16'd1, "after_rst");

        // Random pairs checked against the division invariants.
        for (int n = 0; n < 1000; n++) begin
            logic [15:0] dd;
            logic [15:0] dv;
            dd = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       dv = 16'($urandom_range(0, 15));
                1:       dv = 16'($urandom_range(0, 255));
                default: dv = 16'($urandom);
            endcase
            do_op(dd, dv, 1'b0, 16'd0, 16'd0, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc4_divider_iter.md
# lc4_divider_iter

Iterative 16-bit unsigned divider for the LC4 datapath, the multi-cycle counterpart of the carry-lookahead adder: it computes quotient and remainder by restoring division. Each trial subtraction is `cla16(a, ~b, 1)`. It sits beside the ALU as a long-latency functional unit behind a valid/ready handshake, so the pipeline can stall on DIV/MOD without holding the combinational ALU path.

## Interface
Parameters:
- `STEPS_PER_CYCLE`, default 1: quotient bits resolved per clock.
  - Legal values are 1, 2 and 4.
  - Iteration count is `N = 16/STEPS_PER_CYCLE`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `i_valid` in 1: operands presented.
- `i_ready` out 1: unit idle, can accept.
- `i_dividend` in 16: unsigned dividend.
- `i_divisor` in 16: unsigned divisor.
- `o_valid` out 1: result available.
- `o_ready` in 1: consumer takes result.
- `o_quotient` out 16: quotient.
- `o_remainder` out 16: remainder.

## Operation
- States: IDLE, RUN, DONE.
- Reset (`rst_n`=0 at an edge):
  - state IDLE, counter 0, quotient/remainder registers 0.
  - Outputs: `i_ready`=1, `o_valid`=0, `o_quotient`=0, `o_remainder`=0.
- IDLE:
  - `i_ready`=1.
  - On `i_valid & i_ready`, latch the operands.
  - If divisor≠0: rem←0, quot←dividend, count←N, go to RUN.
  - If divisor==0: quot←0, rem←0, go directly to DONE (LC4 divide-by-zero semantics).
- RUN: each cycle performs `STEPS_PER_CYCLE` chained restoring steps, then count←count−1. When count reaches 1 at an edge, the next state is DONE.
- One restoring step:
  - sh = {rem[14:0], quot[15]}; carry = rem[15].
  - diff = cla16(sh, ~divisor, 1).
  - ok = carry | (sh ≥ divisor), a 17-bit comparison.
  - rem ← ok ? diff : sh.
  - quot ← {quot[14:0], ok}.
- DONE:
  - `o_valid`=1; `o_quotient`/`o_remainder` show the registers.
  - On `o_ready`=1, go to IDLE.
- `i_ready`=1 only in IDLE.
  - `i_valid` in RUN/DONE is ignored; no queueing.
  - No same-cycle accept on the DONE→IDLE edge.
- Outputs are always driven from registers.
  - During RUN they hold partial values; consumers must qualify with `o_valid`.
- Reset mid-RUN or mid-DONE: the operation is discarded. The next cycle shows the reset output values.
- Result invariants:
  - divisor≠0: dividend = quot·divisor + rem, with rem < divisor.
  - divisor=0: quot = 0, rem = 0.

## Timing
- Cycle 0 is the handshake cycle (`i_valid & i_ready`).
- divisor≠0: RUN occupies cycles 1..N; `o_valid` first asserts in cycle N+1.
  - 17 for `STEPS_PER_CYCLE`=1, 9 for 2, 5 for 4.
- divisor=0: `o_valid` asserts in cycle 1.
- `o_valid` and the result outputs stay stable until the cycle where `o_ready`=1.
  - Next cycle: `o_valid`=0, `i_ready`=1.
- Minimum issue interval: N+2 cycles with `o_ready` tied high.
- The critical path is `STEPS_PER_CYCLE` chained cla16 subtract-and-select stages.

## Structure
- Shared package `lc4_div_pkg` holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - `DIV_W`=16;
  - the counter width `$clog2(16)+1`.
- One sub-module, `lc4_div_step`: combinational single restoring step.
  - Inputs: rem, quot, divisor. Outputs: rem', quot'.
  - Instantiates `cla16` internally.
  - The top level chains `STEPS_PER_CYCLE` instances through a generate loop.
- Top level holds the FSM, counter and operand/result registers.

## Test plan
- 100/7, `o_ready`=1 → `o_valid` in cycle 17; q=14, r=2; `i_ready`=1 in cycle 18.
- 0xFFFF/1 and 0xFFFE/0x8001 → q=0xFFFF, r=0; then q=1, r=0x7FFD. The second exercises the carry=rem[15] path.
- 5/0 → `o_valid` in cycle 1; q=0, r=0.
- Back-pressure:
  - 1000/3 with `o_ready`=0 for 5 cycles after `o_valid` → q=333, r=1 held stable.
  - `i_valid` pulses during RUN/DONE are ignored (`i_ready`=0).
  - Completes on the first `o_ready`=1.
- Reset at cycle 8 of a 0x1234/0x0011 divide → next cycle `i_ready`=1, `o_valid`=0, outputs 0. A new 9/4 then yields q=2, r=1.
- Repeat the first two cases with `STEPS_PER_CYCLE`=2 and 4 → same results, `o_valid` in cycles 9 and 5. Add 1000 random pairs checked against the invariants.
